// File: rtl/trigger_capture.sv
// trigger_capture: acquisition-side writer for the scope frame handoff.
// Shifts the ADC sample stream into a DEPTH-entry time-ordered window,
// detects a level/slope (or forced) trigger, and after a full pre/post
// window requests a copy via read/ready, freezing the window until done.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   run          acquisition enable (level)
//   sample_valid sample strobe
//   sample       unsigned ADC sample
//   trig_level   unsigned trigger threshold
//   trig_slope   0 = rising, 1 = falling
//   force_trig   force a trigger while armed
//   ready        copier status: 1 = idle, 0 = waiting/copying
//   read         copy request to the copier
//   data         window, data[0] oldest, data[DEPTH-1] newest
//   armed        high while waiting for a trigger
//   trig_pulse   one-cycle pulse when the trigger sample is registered
module trigger_capture #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned PRETRIG = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          sample_valid,
  input  logic [WIDTH-1:0]              sample,
  input  logic [WIDTH-1:0]              trig_level,
  input  logic                          trig_slope,
  input  logic                          force_trig,
  input  logic                          ready,
  output logic                          read,
  output logic [DEPTH-1:0][WIDTH-1:0]   data,
  output logic                          armed,
  output logic                          trig_pulse
);

  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam int unsigned PRE_LAST  = PRETRIG - 1;
  localparam int unsigned POST_LAST = DEPTH - 2 - PRETRIG;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_PRE,
    S_ARMED,
    S_POST,
    S_REQ,
    S_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] prev;
  logic             force_pend, fp_nxt;
  logic             seen_ready, seen_nxt;
  logic             shift;
  logic             trig_nxt;
  logic             level_hit;

  // Level/slope crossing between the previous shifted sample and this one.
  always_comb begin
    level_hit = 1'b0;
    if (trig_slope) level_hit = (prev > trig_level) && (sample <= trig_level);
    else            level_hit = (prev < trig_level) && (sample >= trig_level);
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fp_nxt    = force_pend;
    seen_nxt  = seen_ready;
    shift     = 1'b0;
    trig_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        fp_nxt = 1'b0;
        if (run) begin
          state_nxt = S_FILL_PRE;
          cnt_nxt   = '0;
        end
      end
      S_FILL_PRE: begin
        shift = sample_valid;
        if (!run) begin
          state_nxt = S_IDLE;
        end else if (sample_valid) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(PRE_LAST)) state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        shift = sample_valid;
        if (force_trig) fp_nxt = 1'b1;
        if (!run) begin
          state_nxt = S_IDLE;
          fp_nxt    = 1'b0;
        end else if (sample_valid && (force_pend || force_trig || level_hit)) begin
          state_nxt = S_POST;
          cnt_nxt   = '0;
          trig_nxt  = 1'b1;
          fp_nxt    = 1'b0;
        end
      end
      S_POST: begin
        shift = sample_valid;
        if (sample_valid) begin
          if (cnt == CW'(POST_LAST)) begin
            state_nxt = S_REQ;
            seen_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      S_REQ: begin
        // A copier already busy on entry is stale; require idle then busy.
        if (ready)           seen_nxt  = 1'b1;
        else if (seen_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (ready) begin
          if (run) begin
            state_nxt = S_FILL_PRE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, window and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      prev       <= '0;
      force_pend <= 1'b0;
      seen_ready <= 1'b0;
      data       <= '0;
      read       <= 1'b0;
      armed      <= 1'b0;
      trig_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      force_pend <= fp_nxt;
      seen_ready <= seen_nxt;
      if (shift) begin
        data <= {sample, data[DEPTH-1:1]};
        prev <= sample;
      end
      read       <= (state_nxt == S_REQ);
      armed      <= (state_nxt == S_ARMED);
      trig_pulse <= trig_nxt;
    end
  end

endmodule
